// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: the reduction polynomial, xtime, and the
// 256-entry round-constant table used by both Rcon and key expansion.
package aes_pkg;

   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef logic [0:255][7:0] rcon_table_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   // Walk x^0..x^254 once; index 0 is x^-1, which equals x^254 (the group order is 255).
   function automatic rcon_table_t gen_rcon_table();
      rcon_table_t t;
      logic [7:0]  b;
      t = '0;
      b = 8'h01;
      for (int k = 1; k < 256; k++) begin
         t[k[7:0]] = b;
         b         = xtime(b);
      end
      t[0] = t[255];
      return t;
   endfunction

   localparam rcon_table_t RCON_TABLE = gen_rcon_table();

endpackage

// File: rtl/aes_rcon_lut.sv
// Purely combinational round-index to Rcon byte lookup.
module aes_rcon_lut
   import aes_pkg::*;
(
   input  logic [7:0] idx_i,
   output logic [7:0] rcon_o
);

   assign rcon_o = RCON_TABLE[idx_i];

endmodule

// File: rtl/aes_rcon.sv
// AES round-constant generator: table lookup plus optional output register
// and a valid flag that rises on the first clock edge after reset.
module aes_rcon
   import aes_pkg::*;
#(
   parameter bit REG_OUT = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i,
   output logic [7:0] o,
   output logic       o_valid
);

   logic [7:0] rcon_d;
   logic       valid_q;

   aes_rcon_lut u_lut (
      .idx_i  (i),
      .rcon_o (rcon_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b1;
      end
   end

   assign o_valid = valid_q;

   generate
      if (REG_OUT) begin : g_reg
         logic [7:0] rcon_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rcon_q <= 8'h00;
            end else begin
               rcon_q <= rcon_d;
            end
         end

         assign o = rcon_q;
      end else begin : g_comb
         // Unregistered build: reset only affects o_valid.
         assign o = rcon_d;
      end
   endgenerate

endmodule

// File: tb/tb_aes_rcon.sv
// Bench for aes_rcon: driver pushes expected Rcon bytes, monitor pops and
// compares one cycle later whenever o_valid is high.
module tb_aes_rcon;

   logic       clk;
   logic       rst_n;
   logic [7:0] i;
   logic [7:0] o;
   logic       o_valid;

   logic [7:0] exp_q[$];
   int         n_cmp;
   int         n_fail;
   logic       mon_en;

   aes_rcon #(.REG_OUT(1'b1)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i       (i),
      .o       (o),
      .o_valid (o_valid)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] m_xtime(input logic [7:0] b);
      logic [7:0] r;
      r = b << 1;
      if (b[7]) r = r ^ 8'h1B;
      return r;
   endfunction

   function automatic logic [7:0] ref_rcon(input logic [7:0] idx);
      int         e;
      logic [7:0] b;
      e = (idx == 8'd0) ? 254 : int'(idx) - 1;
      b = 8'h01;
      for (int k = 0; k < e; k++) b = m_xtime(b);
      return b;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_idx(input logic [7:0] idx, input logic [7:0] exp);
      @(negedge clk);
      i = idx;
      exp_q.push_back(exp);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(posedge clk) begin
      #1;
      if (mon_en && o_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_output: got %h with empty queue at %0t", o, $time);
         end else begin
            check("rcon", {24'h0, o}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] dir_exp [0:14];

   initial begin
      dir_exp = '{8'h8D, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                  8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};
      n_cmp  = 0;
      n_fail = 0;
      mon_en = 1'b1;
      rst_n  = 1'b0;
      i      = 8'd5;

      // Reset held while clock toggles
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("reset_o", {24'h0, o}, 32'h0);
         check("reset_valid", {31'h0, o_valid}, 32'h0);
      end

      // Release: first edge gives f(5)=10
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(8'h10);
      @(posedge clk);
      #2;
      check("valid_after_release", {31'h0, o_valid}, 32'h1);

      // Directed sweep 0..14 with hand-computed values and key-word XOR
      for (int k = 0; k < 15; k++) begin
         drive_idx(k[7:0], dir_exp[k]);
         if (k == 1 || k == 9) begin
            @(posedge clk);
            #2;
            check(k == 1 ? "word_xor_i1" : "word_xor_i9",
                  32'hA0FAFE17 ^ {24'h0, o},
                  k == 1 ? 32'hA0FAFE16 : 32'hA0FAFE0C);
         end
      end

      // Exhaustive sweep against the iterated-xtime model
      for (int k = 0; k < 256; k++) begin
         if (k == 255) drive_idx(8'd255, 8'h8D);
         else          drive_idx(k[7:0], ref_rcon(k[7:0]));
      end
      drive_idx(8'd128, ref_rcon(8'd128));

      // Async reset between edges while i=7; in-flight value discarded
      drive_idx(8'd6, 8'h20);
      @(negedge clk);
      i = 8'd7;
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("async_reset_o", {24'h0, o}, 32'h0);
      check("async_reset_valid", {31'h0, o_valid}, 32'h0);
      @(posedge clk);
      #1;
      check("reset_hold_o", {24'h0, o}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(8'h40);

      // Hold i=10 for five cycles
      for (int k = 0; k < 5; k++) drive_idx(8'd10, 8'h36);

      // Glitch before the edge, then glitch just after the edge
      @(negedge clk);
      i = 8'd10;
      exp_q.push_back(8'h36);
      #1 i = 8'd3;
      #1 i = 8'd10;
      @(posedge clk);
      #2 i = 8'd3;
      #1;
      check("glitch_after_edge", {24'h0, o}, 32'h36);
      i = 8'd10;
      drive_idx(8'd10, 8'h36);

      // Drain the scoreboard
      @(posedge clk);
      #3;
      mon_en = 1'b0;
      check("queue_drained", exp_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_rcon.md
Name: aes_rcon

Overview:
- AES round-constant generator. Maps an 8-bit round index to the 8-bit Rcon byte, defined as x^(i-1) in GF(2^8) modulo the AES polynomial 0x11B.
- Output is registered.
- Sits beside the key-expansion datapath. The consumer XORs the byte into the expanded-key word, at the byte lane the consumer chooses.

Parameters:
- REG_OUT, 1, when 1 the output is registered (1-cycle latency); when 0 the output is combinational from i and reset only clears o_valid. Default build and all verification use REG_OUT=1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- i  input  8  round index, sampled every rising edge.
- o  output  8  Rcon byte for the index sampled on the previous edge.
- o_valid  output  1  0 from reset until the first rising edge after reset deasserts; 1 thereafter.

Behaviour:
- Function: o = x^((i-1) mod 255) in GF(2^8), polynomial 0x11B, for every i in 0..255. No index is undefined.
- Required values:
  - i=1..10 -> 01 02 04 08 10 20 40 80 1B 36.
  - i=11 -> 6C, i=12 -> D8, i=13 -> AB, i=14 -> 4D.
  - i=0 -> 8D (x^-1). i=255 -> 8D. i=256 wraps to i=0 by the 8-bit width.
- Sequence rule: f(i+1) = xtime(f(i)). xtime(b) = (b<<1) XOR (b[7] ? 0x1B : 0x00), truncated to 8 bits.
- Implementation: full 256-entry constant case table, or an equivalent exponentiation network. Result must be bit-exact with the rule above. No X on o for any i.
- Latency (REG_OUT=1): i applied before edge N appears on o after edge N. Exactly 1 cycle; no handshake; a new index is accepted every cycle.
- Reset: rst_n low asynchronously forces o=0x00 and o_valid=0, independent of clk.
  - Reset mid-stream discards the in-flight value.
  - On the first edge after rst_n rises, o = f(i) and o_valid = 1.
- An unchanged i holds o constant.
- i changing between edges has no effect until the next edge (REG_OUT=1).
- The block has no internal state beyond the output register and o_valid.

Decomposition:
- Shared package aes_pkg holds:
  - the constant AES_POLY = 8'h1B;
  - a function xtime(byte);
  - a localparam array RCON_TABLE[0:255] generated from the rule above. The key-expansion block reuses this table.
- Natural sub-module: aes_rcon_lut, a purely combinational index-to-byte table. aes_rcon wraps it with the output register and o_valid.

Test Plan:
- Reset: hold rst_n=0 with i=5 and toggle clk -> o=00, o_valid=0 throughout. Release; after the first edge -> o=10, o_valid=1.
- Sweep i=0..11, one per cycle -> o sequence 8D 01 02 04 08 10 20 40 80 1B 36 6C, each one cycle after its index. With word W=0xA0FAFE17: W XOR zero-extended o at i=1 gives 0xA0FAFE16, and at i=9 gives 0xA0FAFE0C.
- Exhaustive sweep i=0..255 -> o equals the xtime-iterated reference model each cycle. Check i=255 -> 8D and i=128 -> x^127 per the model.
- Async reset mid-sweep: assert rst_n between edges while i=7 -> o drops to 00 immediately, with no wait for the clock edge. Deassert -> next edge gives f(current i).
- Hold and glitch: keep i=10 for 5 cycles -> o=36 stable. Pulse i to 3 and back to 10 between edges -> o stays 36.
